// File: rtl/wb_pkg.sv
// Shared types for the writeback port arbiter: register-file select, buffered
// LLU entry, and the x0 null-write test used by both write sources.
package wb_pkg;
  typedef enum logic {RF_INT = 1'b0, RF_FLOAT = 1'b1} rf_sel_t;

  typedef struct packed {
    rf_sel_t     file;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  function automatic logic is_null_write(rf_sel_t file, logic [4:0] rd);
    return (file == RF_INT) && (rd == 5'd0);
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries; pointers wrap modulo DEPTH
// (power of two), count is one bit wider than the pointers.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  wb_entry_t                push_data,
  input  logic                     pop,
  output wb_entry_t                pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  wb_entry_t       mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the int/float RF write ports between the MEM/WB stream (priority) and
// buffered LLU results, stalling the pipeline once a head entry has starved.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wb_we,
  input  logic                        wb_float,
  input  logic [4:0]                  wb_rd,
  input  logic [31:0]                 wb_data,
  input  logic                        llu_valid,
  output logic                        llu_ready,
  input  logic                        llu_float,
  input  logic [4:0]                  llu_rd,
  input  logic [31:0]                 llu_data,
  output logic                        pipe_stall,
  output logic                        irf_we,
  output logic [4:0]                  irf_waddr,
  output logic [31:0]                 irf_wdata,
  output logic                        frf_we,
  output logic [4:0]                  frf_waddr,
  output logic [31:0]                 frf_wdata,
  output logic [$clog2(BUF_DEPTH):0]  buf_count
);
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  wb_entry_t        llu_entry, head;
  logic             full, empty, push, pop;
  rf_sel_t          p_file;
  logic             p_vld, h_vld, h_null, conflict, issue_p, issue_h;
  logic [AGE_W-1:0] age_q, age_d;
  logic             irf_we_q, irf_we_d, frf_we_q, frf_we_d;
  logic [4:0]       irf_waddr_q, irf_waddr_d, frf_waddr_q, frf_waddr_d;
  logic [31:0]      irf_wdata_q, irf_wdata_d, frf_wdata_q, frf_wdata_d;

  assign llu_ready = !full && rst_n;
  assign push      = llu_valid && llu_ready;
  assign llu_entry = '{file: rf_sel_t'(llu_float), rd: llu_rd, data: llu_data};
  assign pipe_stall = (age_q == AGE_W'(STARVE_LIMIT)) && !empty;

  wb_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (llu_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (buf_count)
  );

  always_comb begin
    p_file   = rf_sel_t'(wb_float);
    p_vld    = wb_we && !is_null_write(p_file, wb_rd);
    h_vld    = !empty;
    h_null   = is_null_write(head.file, head.rd);
    // A null head never competes for a port, so it cannot be a conflict.
    conflict = h_vld && p_vld && !h_null && (head.file == p_file);
    issue_p  = p_vld && !pipe_stall;
    issue_h  = h_vld && (pipe_stall || !conflict);
    pop      = issue_h;

    age_d = age_q;
    if (pop) age_d = '0;
    else if (conflict && (age_q < AGE_W'(STARVE_LIMIT))) age_d = age_q + AGE_W'(1);

    irf_we_d    = 1'b0;
    irf_waddr_d = irf_waddr_q;
    irf_wdata_d = irf_wdata_q;
    frf_we_d    = 1'b0;
    frf_waddr_d = frf_waddr_q;
    frf_wdata_d = frf_wdata_q;
    if (issue_p) begin
      if (p_file == RF_FLOAT) begin
        frf_we_d = 1'b1; frf_waddr_d = wb_rd; frf_wdata_d = wb_data;
      end else begin
        irf_we_d = 1'b1; irf_waddr_d = wb_rd; irf_wdata_d = wb_data;
      end
    end
    if (issue_h && !h_null) begin
      if (head.file == RF_FLOAT) begin
        frf_we_d = 1'b1; frf_waddr_d = head.rd; frf_wdata_d = head.data;
      end else begin
        irf_we_d = 1'b1; irf_waddr_d = head.rd; irf_wdata_d = head.data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q       <= '0;
      irf_we_q    <= 1'b0;
      irf_waddr_q <= '0;
      irf_wdata_q <= '0;
      frf_we_q    <= 1'b0;
      frf_waddr_q <= '0;
      frf_wdata_q <= '0;
    end else begin
      age_q       <= age_d;
      irf_we_q    <= irf_we_d;
      irf_waddr_q <= irf_waddr_d;
      irf_wdata_q <= irf_wdata_d;
      frf_we_q    <= frf_we_d;
      frf_waddr_q <= frf_waddr_d;
      frf_wdata_q <= frf_wdata_d;
    end
  end

  assign irf_we    = irf_we_q;
  assign irf_waddr = irf_waddr_q;
  assign irf_wdata = irf_wdata_q;
  assign frf_we    = frf_we_q;
  assign frf_waddr = frf_waddr_q;
  assign frf_wdata = frf_wdata_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with BUF_DEPTH=2, STARVE_LIMIT=8.
module tb_wb_port_arbiter;
  logic        clk, rst_n;
  logic        wb_we, wb_float, llu_valid, llu_float;
  logic [4:0]  wb_rd, llu_rd;
  logic [31:0] wb_data, llu_data;
  logic        llu_ready, pipe_stall, irf_we, frf_we;
  logic [4:0]  irf_waddr, frf_waddr;
  logic [31:0] irf_wdata, frf_wdata;
  logic [1:0]  buf_count;
  int          errors = 0;
  int          checks = 0;

  wb_port_arbiter #(.BUF_DEPTH(2), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_float(wb_float), .wb_rd(wb_rd), .wb_data(wb_data),
    .llu_valid(llu_valid), .llu_ready(llu_ready), .llu_float(llu_float),
    .llu_rd(llu_rd), .llu_data(llu_data), .pipe_stall(pipe_stall),
    .irf_we(irf_we), .irf_waddr(irf_waddr), .irf_wdata(irf_wdata),
    .frf_we(frf_we), .frf_waddr(frf_waddr), .frf_wdata(frf_wdata),
    .buf_count(buf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All outputs depend only on registered state, so sampling 1 time unit after
  // the edge and then driving the next inputs is safe.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_pipe(input logic we, input logic fl, input logic [4:0] rd, input logic [31:0] d);
    wb_we = we; wb_float = fl; wb_rd = rd; wb_data = d;
  endtask

  task automatic set_llu(input logic v, input logic fl, input logic [4:0] rd, input logic [31:0] d);
    llu_valid = v; llu_float = fl; llu_rd = rd; llu_data = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    set_pipe(0, 0, 0, 0);
    set_llu(0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #2;
    checks++; if (irf_we !== 1'b0) begin errors++; $display("FAIL rst_irf_we got=%0b exp=0", irf_we); end
    checks++; if (frf_we !== 1'b0) begin errors++; $display("FAIL rst_frf_we got=%0b exp=0", frf_we); end
    checks++; if (buf_count !== 2'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", buf_count); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%0b exp=0", pipe_stall); end
    checks++; if (llu_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%0b exp=0", llu_ready); end
    checks++; if (irf_waddr !== 5'd0 || frf_wdata !== 32'd0) begin errors++; $display("FAIL rst_addr_data got=%0d/%h exp=0/0", irf_waddr, frf_wdata); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    checks++; if (llu_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got=%0b exp=1", llu_ready); end
  endtask

  task automatic test_pipe_write();
    set_pipe(1, 0, 5'd5, 32'hDEADBEEF);
    step();
    set_pipe(0, 0, 0, 0);
    checks++; if (irf_we !== 1'b1 || irf_waddr !== 5'd5 || irf_wdata !== 32'hDEADBEEF)
      begin errors++; $display("FAIL pipe_int got=%0b/%0d/%h exp=1/5/deadbeef", irf_we, irf_waddr, irf_wdata); end
    checks++; if (frf_we !== 1'b0) begin errors++; $display("FAIL pipe_frf_we got=%0b exp=0", frf_we); end
    step();
    checks++; if (irf_we !== 1'b0) begin errors++; $display("FAIL pipe_idle got=%0b exp=0", irf_we); end
  endtask

  task automatic test_dual_port();
    set_pipe(1, 0, 5'd7, 32'h0000_0707);
    set_llu(1, 1, 5'd3, 32'h3F800000);
    step();
    set_llu(0, 0, 0, 0);
    checks++; if (buf_count !== 2'd1 || irf_we !== 1'b1 || frf_we !== 1'b0)
      begin errors++; $display("FAIL dual_push got=%0d/%0b/%0b exp=1/1/0", buf_count, irf_we, frf_we); end
    step();
    set_pipe(0, 0, 0, 0);
    checks++; if (irf_we !== 1'b1 || irf_waddr !== 5'd7 || frf_we !== 1'b1 || frf_waddr !== 5'd3 || frf_wdata !== 32'h3F800000)
      begin errors++; $display("FAIL dual_both got=%0b/%0d/%0b/%0d/%h exp=1/7/1/3/3f800000", irf_we, irf_waddr, frf_we, frf_waddr, frf_wdata); end
    checks++; if (buf_count !== 2'd0 || pipe_stall !== 1'b0)
      begin errors++; $display("FAIL dual_drain got=%0d/%0b exp=0/0", buf_count, pipe_stall); end
  endtask

  task automatic test_starve();
    set_pipe(1, 1, 5'd9, 32'h11);
    set_llu(1, 1, 5'd2, 32'h22);
    step();
    set_llu(0, 0, 0, 0);
    checks++; if (buf_count !== 2'd1) begin errors++; $display("FAIL starve_push got=%0d exp=1", buf_count); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_early_stall cyc=%0d got=%0b exp=0", i, pipe_stall); end
      step();
      checks++; if (frf_we !== 1'b1 || frf_waddr !== 5'd9)
        begin errors++; $display("FAIL starve_pipe cyc=%0d got=%0b/%0d exp=1/9", i, frf_we, frf_waddr); end
    end
    checks++; if (pipe_stall !== 1'b1) begin errors++; $display("FAIL starve_stall got=%0b exp=1", pipe_stall); end
    step();
    checks++; if (frf_we !== 1'b1 || frf_waddr !== 5'd2 || frf_wdata !== 32'h22)
      begin errors++; $display("FAIL starve_llu got=%0b/%0d/%h exp=1/2/22", frf_we, frf_waddr, frf_wdata); end
    checks++; if (pipe_stall !== 1'b0 || buf_count !== 2'd0)
      begin errors++; $display("FAIL starve_release got=%0b/%0d exp=0/0", pipe_stall, buf_count); end
    step();
    set_pipe(0, 0, 0, 0);
    checks++; if (frf_we !== 1'b1 || frf_waddr !== 5'd9)
      begin errors++; $display("FAIL starve_reissue got=%0b/%0d exp=1/9", frf_we, frf_waddr); end
  endtask

  task automatic test_full();
    int n;
    set_pipe(1, 1, 5'd9, 32'h99);
    set_llu(1, 1, 5'd10, 32'hA0);
    step();
    checks++; if (llu_ready !== 1'b1 || buf_count !== 2'd1)
      begin errors++; $display("FAIL full_first got=%0b/%0d exp=1/1", llu_ready, buf_count); end
    set_llu(1, 1, 5'd11, 32'hA1);
    step();
    checks++; if (llu_ready !== 1'b0 || buf_count !== 2'd2)
      begin errors++; $display("FAIL full_block got=%0b/%0d exp=0/2", llu_ready, buf_count); end
    set_llu(1, 1, 5'd12, 32'hA2);
    n = 0;
    while (!llu_ready && n < 20) begin step(); n++; end
    checks++; if (n != 8) begin errors++; $display("FAIL full_wait got=%0d exp=8", n); end
    checks++; if (buf_count !== 2'd1 || frf_waddr !== 5'd10)
      begin errors++; $display("FAIL full_pop got=%0d/%0d exp=1/10", buf_count, frf_waddr); end
    step();
    set_llu(0, 0, 0, 0);
    set_pipe(0, 0, 0, 0);
    checks++; if (buf_count !== 2'd2) begin errors++; $display("FAIL full_third got=%0d exp=2", buf_count); end
    step();
    checks++; if (frf_we !== 1'b1 || frf_waddr !== 5'd11 || buf_count !== 2'd1)
      begin errors++; $display("FAIL full_drain1 got=%0b/%0d/%0d exp=1/11/1", frf_we, frf_waddr, buf_count); end
    step();
    checks++; if (frf_we !== 1'b1 || frf_waddr !== 5'd12 || buf_count !== 2'd0)
      begin errors++; $display("FAIL full_drain2 got=%0b/%0d/%0d exp=1/12/0", frf_we, frf_waddr, buf_count); end
  endtask

  task automatic test_null();
    set_pipe(1, 0, 5'd0, 32'h55);
    set_llu(1, 0, 5'd0, 32'h66);
    step();
    set_llu(0, 0, 0, 0);
    set_pipe(1, 0, 5'd6, 32'h77);
    checks++; if (irf_we !== 1'b0 || buf_count !== 2'd1)
      begin errors++; $display("FAIL null_pipe got=%0b/%0d exp=0/1", irf_we, buf_count); end
    step();
    set_pipe(0, 0, 0, 0);
    checks++; if (irf_we !== 1'b1 || irf_waddr !== 5'd6 || irf_wdata !== 32'h77 || buf_count !== 2'd0)
      begin errors++; $display("FAIL null_head got=%0b/%0d/%h/%0d exp=1/6/77/0", irf_we, irf_waddr, irf_wdata, buf_count); end
    step();
    checks++; if (irf_we !== 1'b0 || pipe_stall !== 1'b0)
      begin errors++; $display("FAIL null_after got=%0b/%0b exp=0/0", irf_we, pipe_stall); end
  endtask

  task automatic test_reset_mid();
    set_pipe(1, 1, 5'd9, 32'h99);
    set_llu(1, 1, 5'd20, 32'hB0);
    step();
    set_llu(1, 1, 5'd21, 32'hB1);
    step();
    set_llu(0, 0, 0, 0);
    repeat (4) step();
    checks++; if (buf_count !== 2'd2 || pipe_stall !== 1'b0)
      begin errors++; $display("FAIL mid_setup got=%0d/%0b exp=2/0", buf_count, pipe_stall); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (irf_we !== 1'b0 || frf_we !== 1'b0 || buf_count !== 2'd0 || pipe_stall !== 1'b0 || llu_ready !== 1'b0)
      begin errors++; $display("FAIL mid_reset got=%0b/%0b/%0d/%0b/%0b exp=0/0/0/0/0", irf_we, frf_we, buf_count, pipe_stall, llu_ready); end
    checks++; if (frf_waddr !== 5'd0 || frf_wdata !== 32'd0)
      begin errors++; $display("FAIL mid_reset_data got=%0d/%h exp=0/0", frf_waddr, frf_wdata); end
    set_pipe(0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    checks++; if (llu_ready !== 1'b1 || buf_count !== 2'd0 || frf_we !== 1'b0)
      begin errors++; $display("FAIL mid_release got=%0b/%0d/%0b exp=1/0/0", llu_ready, buf_count, frf_we); end
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_dual_port();
    test_starve();
    test_full();
    test_null();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the integer and float register-file write ports between the in-order MEM/WB writeback stream and one long-latency unit (LLU: float divide/sqrt, convolution accumulator drain). Sits after the MEM/WB pipeline register and drives both register-file write ports. Pipeline writes have priority. LLU results are buffered in a small FIFO and issued on the idle port or the non-conflicting port. A starvation guard stalls the pipeline when an LLU result has waited too long.

## Interface
Parameters:
- BUF_DEPTH, 2, LLU result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 8, consecutive conflict cycles before a forced pipeline stall (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- wb_we  in  1  pipeline writeback request (regwrite of selected file)
- wb_float  in  1  0 = integer file, 1 = float file
- wb_rd  in  5  destination register
- wb_data  in  32  writeback data (already muxed memtoreg)
- llu_valid  in  1  LLU result valid
- llu_ready  out  1  FIFO can accept
- llu_float  in  1  LLU destination file
- llu_rd  in  5  LLU destination register
- llu_data  in  32  LLU result
- pipe_stall  out  1  pipeline must hold MEM/WB this cycle
- irf_we / irf_waddr / irf_wdata  out  1/5/32  integer RF write port
- frf_we / frf_waddr / frf_wdata  out  1/5/32  float RF write port
- buf_count  out  $clog2(BUF_DEPTH)+1  occupied FIFO entries

## Operation
- LLU push on llu_valid && llu_ready. llu_ready = (buf_count < BUF_DEPTH) && rst_n. There is no bypass, so ready stays low when full even if a pop occurs the same cycle.
- Integer target with rd = 0 is a null write from either source. It never drives irf_we and never counts as a conflict. An x0 head entry is popped with no write.
- Per cycle, with H = FIFO head (if any) and P = pipeline request (if wb_we and not null):
  - Stall cycle (pipe_stall = 1): P is ignored, H is issued and popped, age is cleared. The pipeline re-presents the same P next cycle.
  - No H: P is issued.
  - H and P target different files, or no P: both are issued, H is popped, age is cleared.
  - H and P target the same file: only P is issued, age increments (saturating at STARVE_LIMIT).
- pipe_stall = (age == STARVE_LIMIT) && (buf_count != 0). It is combinational from registered state.
- A new head starts with age 0. Write order to the same register follows issue order.

## Timing
- RF port outputs are registered. A write selected in cycle n appears on irf_*/frf_* after edge n.
- Pipeline write: presented in cycle n, RF port valid in cycle n+1 (no conflict penalty, ever).
- LLU: accepted at edge k, earliest issue in cycle k, so the write is on the RF port in cycle k+1.
- Worst-case wait for a head entry: STARVE_LIMIT conflict cycles plus 1 stall cycle.
- Reset (async assert, any time):
  - FIFO flushed, buf_count = 0, age = 0.
  - irf_we = frf_we = 0, addresses and data = 0.
  - pipe_stall = 0, llu_ready = 0 while rst_n is low.
  - In-flight LLU entries are lost. The LLU is reset by the same rst_n.
- Simultaneous push and pop at an intermediate count: count is unchanged and both occur.
- FIFO pointers wrap modulo BUF_DEPTH.

## Structure
- Shared package wb_pkg:
  - rf_sel_t enum (RF_INT, RF_FLOAT)
  - wb_entry_t struct {rf_sel_t file; logic [4:0] rd; logic [31:0] data}
  - function is_null_write(file, rd)
- Sub-module wb_fifo: parameterised synchronous FIFO of wb_entry_t with push/pop/full/empty/count and async active-low reset. The arbiter holds the issue logic, age counter and output registers.

## Test plan
- Idle LLU, pipeline wb_we=1, int, rd=5, data=0xDEADBEEF → next cycle irf_we=1, irf_waddr=5, irf_wdata=0xDEADBEEF, frf_we=0.
- LLU float rd=3 data=0x3F800000 while pipeline writes int rd=7 every cycle → both ports write in the same cycle, no stall, buf_count returns to 0.
- LLU float rd=2 pushed while pipeline writes float every cycle, STARVE_LIMIT=8 → 8 pipeline-only cycles, then pipe_stall=1 for exactly 1 cycle with frf_waddr=2 the following cycle; pipeline write then re-issued.
- Push 3 LLU results against a continuous same-file pipeline stream, BUF_DEPTH=2 → llu_ready=0 after 2 accepts, third held by LLU until a pop frees space.
- Pipeline int rd=0 and LLU int rd=0 → no irf_we, LLU entry popped, no conflict counted.
- Assert rst_n=0 with 2 entries buffered and age=5 → all write enables 0, buf_count=0, pipe_stall=0 immediately; after release llu_ready=1 on first cycle.
